// File: rtl/axis_gpio_sequencer.sv
// axis_gpio_sequencer: plays a stream of {hold_delay, value} commands onto GPIO output pins
module axis_gpio_sequencer #(
  parameter int AXIS_TDATA_WIDTH    = 32,
  parameter int GPIO_OUT_DATA_WIDTH = 8,
  parameter int CNTR_WIDTH          = 24
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           enable,
  input  logic                           trigger,
  input  logic [GPIO_OUT_DATA_WIDTH-1:0] idle_data,
  input  logic [AXIS_TDATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [GPIO_OUT_DATA_WIDTH-1:0] gpio_data,
  output logic                           busy,
  output logic                           underrun,
  output logic [31:0]                    sts_count
);
  typedef enum logic [1:0] {IDLE, ARMED, FETCH, DELAY} state_t;
  state_t                         state_q, state_d;
  logic [GPIO_OUT_DATA_WIDTH-1:0] gpio_q, gpio_d;
  logic [CNTR_WIDTH-1:0]          cnt_q, cnt_d;
  logic [31:0]                    sts_q, sts_d;
  logic                           underrun_q, underrun_d;
  logic                           started_q, started_d;
  logic [CNTR_WIDTH-1:0]          cmd_delay;
  logic [GPIO_OUT_DATA_WIDTH-1:0] cmd_value;
  assign cmd_delay     = s_axis_tdata[AXIS_TDATA_WIDTH-1:GPIO_OUT_DATA_WIDTH];
  assign cmd_value     = s_axis_tdata[GPIO_OUT_DATA_WIDTH-1:0];
  assign s_axis_tready = (state_q == FETCH) & enable;
  assign gpio_data     = gpio_q;
  assign busy          = state_q != IDLE;
  assign underrun      = underrun_q;
  assign sts_count     = sts_q;
  // next-state logic; a low enable overrides every state and freezes status
  always_comb begin
    state_d    = state_q;
    gpio_d     = gpio_q;
    cnt_d      = cnt_q;
    sts_d      = sts_q;
    underrun_d = underrun_q;
    started_d  = started_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      gpio_d  = idle_data;
    end else begin
      case (state_q)
        IDLE: begin
          gpio_d     = idle_data;
          state_d    = ARMED;
          underrun_d = 1'b0;
          started_d  = 1'b0;
          sts_d      = '0;
        end
        ARMED: state_d = trigger ? FETCH : ARMED;
        FETCH: begin
          if (s_axis_tvalid) begin
            gpio_d    = cmd_value;
            cnt_d     = cmd_delay;
            sts_d     = sts_q + 32'd1;
            started_d = 1'b1;
            state_d   = (cmd_delay == '0) ? FETCH : DELAY;
          end else if (started_q) begin
            underrun_d = 1'b1;
          end
        end
        default: begin
          cnt_d   = cnt_q - CNTR_WIDTH'(1);
          state_d = (cnt_q == CNTR_WIDTH'(1)) ? FETCH : DELAY;
        end
      endcase
    end
  end
  // state registers with synchronous reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      gpio_q     <= '0;
      cnt_q      <= '0;
      sts_q      <= '0;
      underrun_q <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gpio_q     <= gpio_d;
      cnt_q      <= cnt_d;
      sts_q      <= sts_d;
      underrun_q <= underrun_d;
      started_q  <= started_d;
    end
  end
endmodule

// File: tb/tb_axis_gpio_sequencer.sv
// tb_axis_gpio_sequencer: vector table plus directed multi-cycle sequences
module tb_axis_gpio_sequencer;
  logic        clk = 1'b0;
  logic        rst, en, trg, tv, rdy, bsy, ur;
  logic [7:0]  idle, gpio;
  logic [17:0] td;
  logic [31:0] sts;
  int          checks = 0;
  int          errors = 0;
  int          n;
  always #5 clk = ~clk;
  axis_gpio_sequencer #(
    .AXIS_TDATA_WIDTH(18), .GPIO_OUT_DATA_WIDTH(8), .CNTR_WIDTH(10)
  ) dut (
    .aclk(clk), .areset(rst), .enable(en), .trigger(trg), .idle_data(idle),
    .s_axis_tdata(td), .s_axis_tvalid(tv), .s_axis_tready(rdy),
    .gpio_data(gpio), .busy(bsy), .underrun(ur), .sts_count(sts)
  );
  typedef struct {
    logic        rst, en, trg;
    logic [7:0]  idle;
    logic        tv;
    logic [17:0] td;
    logic [7:0]  g;
    logic        rdy, bsy, ur;
    logic [31:0] sts;
  } vec_t;
  vec_t vt[17];
  function automatic logic [17:0] cmd(input logic [9:0] d, input logic [7:0] v);
    return {d, v};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input logic [7:0] g, input logic r, input logic b,
                         input logic u, input logic [31:0] s);
    chk({nm, " gpio"}, 32'(gpio), 32'(g));
    chk({nm, " tready"}, 32'(rdy), 32'(r));
    chk({nm, " busy"}, 32'(bsy), 32'(b));
    chk({nm, " underrun"}, 32'(ur), 32'(u));
    chk({nm, " sts"}, sts, s);
  endtask
  initial begin
    //           rst  en   trg  idle   tv   td              gpio   rdy  bsy  ur   sts
    vt[0]  = '{1'b1,1'b0,1'b0,8'h00,1'b1,cmd(3,8'h01),    8'h00,1'b0,1'b0,1'b0,32'd0};
    vt[1]  = '{1'b1,1'b0,1'b0,8'h00,1'b1,cmd(3,8'h01),    8'h00,1'b0,1'b0,1'b0,32'd0};
    vt[2]  = '{1'b1,1'b0,1'b0,8'h00,1'b1,cmd(3,8'h01),    8'h00,1'b0,1'b0,1'b0,32'd0};
    vt[3]  = '{1'b0,1'b0,1'b0,8'hA5,1'b1,cmd(3,8'h01),    8'hA5,1'b0,1'b0,1'b0,32'd0};
    vt[4]  = '{1'b0,1'b1,1'b0,8'hA5,1'b1,cmd(3,8'h01),    8'hA5,1'b0,1'b1,1'b0,32'd0};
    vt[5]  = '{1'b0,1'b1,1'b1,8'hA5,1'b1,cmd(3,8'h01),    8'hA5,1'b1,1'b1,1'b0,32'd0};
    vt[6]  = '{1'b0,1'b1,1'b0,8'hA5,1'b1,cmd(3,8'h01),    8'h01,1'b0,1'b1,1'b0,32'd1};
    vt[7]  = '{1'b0,1'b1,1'b0,8'hA5,1'b1,cmd(0,8'h02),    8'h01,1'b0,1'b1,1'b0,32'd1};
    vt[8]  = '{1'b0,1'b1,1'b0,8'hA5,1'b1,cmd(0,8'h02),    8'h01,1'b0,1'b1,1'b0,32'd1};
    vt[9]  = '{1'b0,1'b1,1'b0,8'hA5,1'b1,cmd(0,8'h02),    8'h01,1'b1,1'b1,1'b0,32'd1};
    vt[10] = '{1'b0,1'b1,1'b0,8'hA5,1'b1,cmd(0,8'h02),    8'h02,1'b1,1'b1,1'b0,32'd2};
    vt[11] = '{1'b0,1'b1,1'b0,8'hA5,1'b1,cmd(1,8'h04),    8'h04,1'b0,1'b1,1'b0,32'd3};
    vt[12] = '{1'b0,1'b1,1'b0,8'hA5,1'b0,cmd(1,8'h04),    8'h04,1'b1,1'b1,1'b0,32'd3};
    vt[13] = '{1'b0,1'b1,1'b0,8'hA5,1'b0,cmd(1,8'h04),    8'h04,1'b1,1'b1,1'b1,32'd3};
    vt[14] = '{1'b0,1'b0,1'b0,8'h5A,1'b0,cmd(1,8'h04),    8'h5A,1'b0,1'b0,1'b1,32'd3};
    vt[15] = '{1'b0,1'b1,1'b1,8'h5A,1'b0,cmd(1,8'h04),    8'h5A,1'b0,1'b1,1'b0,32'd0};
    vt[16] = '{1'b0,1'b1,1'b1,8'h5A,1'b0,cmd(1,8'h04),    8'h5A,1'b1,1'b1,1'b0,32'd0};
    for (int i = 0; i < 17; i++) begin
      rst = vt[i].rst; en = vt[i].en; trg = vt[i].trg;
      idle = vt[i].idle; tv = vt[i].tv; td = vt[i].td;
      step();
      chk_all($sformatf("vec%0d", i), vt[i].g, vt[i].rdy, vt[i].bsy, vt[i].ur, vt[i].sts);
    end
    // trigger gating: armed but untriggered for 20 cycles
    trg = 1'b0; en = 1'b0; step();
    en = 1'b1; tv = 1'b1; td = cmd(2, 8'h10);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("gate%0d tready", i), 32'(rdy), 32'd0);
      chk($sformatf("gate%0d busy", i), 32'(bsy), 32'd1);
      chk($sformatf("gate%0d gpio", i), 32'(gpio), 32'h5A);
    end
    trg = 1'b1; step();
    chk("trig edge1 tready", 32'(rdy), 32'd1);
    chk("trig edge1 sts", sts, 32'd0);
    trg = 1'b0; step();
    chk("trig edge2 gpio", 32'(gpio), 32'h10);
    chk("trig edge2 sts", sts, 32'd1);
    // underrun: stream starves after one command
    tv = 1'b0;
    repeat (5) step();
    chk("underrun flag", 32'(ur), 32'd1);
    chk("underrun gpio", 32'(gpio), 32'h10);
    chk("underrun tready", 32'(rdy), 32'd1);
    tv = 1'b1; td = cmd(0, 8'h20); step();
    chk("after underrun gpio", 32'(gpio), 32'h20);
    chk("after underrun sts", sts, 32'd2);
    chk("underrun sticky", 32'(ur), 32'd1);
    tv = 1'b0; en = 1'b0; step();
    en = 1'b1; step();
    chk("rearm underrun", 32'(ur), 32'd0);
    chk("rearm sts", sts, 32'd0);
    // disable in the middle of a long hold
    trg = 1'b1; step();
    trg = 1'b0; tv = 1'b1; td = cmd(100, 8'hFF); step();
    chk("long gpio", 32'(gpio), 32'hFF);
    tv = 1'b0;
    repeat (9) step();
    chk("long hold busy", 32'(bsy), 32'd1);
    chk("long hold gpio", 32'(gpio), 32'hFF);
    en = 1'b0; idle = 8'h3C; step();
    chk_all("disable", 8'h3C, 1'b0, 1'b0, 1'b0, 32'd1);
    // no handshake on the cycle enable drops while in FETCH
    en = 1'b1; step();
    trg = 1'b1; step();
    chk("fetch tready", 32'(rdy), 32'd1);
    trg = 1'b0; en = 1'b0; tv = 1'b1; td = cmd(0, 8'h42); #1;
    chk("drop tready", 32'(rdy), 32'd0);
    step();
    chk("drop gpio", 32'(gpio), 32'h3C);
    chk("drop sts", sts, 32'd0);
    // maximum delay: value held exactly 2^CNTR_WIDTH cycles
    tv = 1'b0; en = 1'b1; trg = 1'b1; step();
    step();
    trg = 1'b0; tv = 1'b1; td = cmd(10'h3FF, 8'h77); step();
    chk("max gpio", 32'(gpio), 32'h77);
    td = cmd(0, 8'h88);
    n = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (gpio != 8'h77) break;
      n++;
    end
    chk("max hold cycles", n, 32'd1024);
    chk("max next gpio", 32'(gpio), 32'h88);
    td = cmd(500, 8'h99); step();
    chk("mid gpio", 32'(gpio), 32'h99);
    chk("mid sts", sts, 32'd3);
    repeat (50) step();
    chk("mid busy", 32'(bsy), 32'd1);
    rst = 1'b1; step();
    chk_all("reset mid", 8'h00, 1'b0, 1'b0, 1'b0, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_gpio_sequencer.md
Name: axis_gpio_sequencer

Overview:
- Timed GPIO output sequencer that feeds the `data` input of the GPIO reader/writer block.
- Consumes an AXI-Stream of commands, each a {hold_delay, value} pair, and drives each value onto the output pins for a programmed number of cycles.
- Gated by an enable and a start trigger.
- Reports accepted-command count, busy and underrun for the PS status registers.

Parameters:
- AXIS_TDATA_WIDTH, 32, command word width; must equal CNTR_WIDTH + GPIO_OUT_DATA_WIDTH.
- GPIO_OUT_DATA_WIDTH, 8, output value width (matches the GPIO writer).
- CNTR_WIDTH, 24, hold-delay counter width.

Ports:
- aclk  input  1  system clock; all logic on rising edge.
- areset  input  1  synchronous, active-high reset.
- enable  input  1  sequencer enable (level).
- trigger  input  1  start trigger (level, sampled in ARMED).
- idle_data  input  GPIO_OUT_DATA_WIDTH  value driven while disabled.
- s_axis_tdata  input  AXIS_TDATA_WIDTH  command: [AXIS_TDATA_WIDTH-1:GPIO_OUT_DATA_WIDTH]=delay D, [GPIO_OUT_DATA_WIDTH-1:0]=value.
- s_axis_tvalid  input  1  command valid.
- s_axis_tready  output  1  command accept.
- gpio_data  output  GPIO_OUT_DATA_WIDTH  registered value to the GPIO writer `data` input.
- busy  output  1  high in ARMED, FETCH and DELAY.
- underrun  output  1  sticky: stream starved while running.
- sts_count  output  32  accepted-command counter.

Behaviour:
- Single clock aclk; reset is synchronous and active-high (areset).
- Reset values: state=IDLE, gpio_data=0, counter=0, sts_count=0, underrun=0, s_axis_tready=0, busy=0.
- States:
  - IDLE: gpio_data<=idle_data every cycle. If enable=1, go to ARMED and clear underrun, the started flag and sts_count.
  - ARMED: gpio_data holds. If trigger=1, go to FETCH.
  - FETCH: s_axis_tready=1. On tvalid (handshake at edge t):
    - gpio_data<=value, visible after edge t;
    - counter<=D;
    - sts_count increments (wraps at 2^32);
    - started<=1;
    - next state is FETCH if D=0, else DELAY.
  - FETCH with tvalid=0: if started=1, set underrun (sticky); gpio_data holds last value; stay in FETCH.
  - DELAY: counter<=counter-1 each cycle. When counter==1, go to FETCH.
- Hold timing: each value is held exactly D+1 cycles before the next handshake is possible. D=0 gives back-to-back acceptance, one command per cycle.
- Maximum D is 2^CNTR_WIDTH-1. No wrap: the counter never decrements below 1 in DELAY.
- s_axis_tready = (state==FETCH) & enable, combinational. No handshake occurs on the cycle enable drops.
- Disable has priority over everything: enable=0 in any state goes to IDLE on the next edge, counter<=0, and gpio_data<=idle_data from that edge on. sts_count and underrun are frozen until the next arm.
- trigger is ignored outside ARMED. Holding trigger high while arming starts the sequence one cycle after ARMED is entered.
- areset mid-sequence returns all state to reset values on the next edge. Any command in flight is dropped and not counted.
- No combinational path from s_axis_tdata to gpio_data. busy is decoded from the state register.

Test Plan:
- Reset and idle:
  - Stimulus: assert areset 3 cycles with tvalid=1.
  - Required: gpio_data=0, tready=0, sts_count=0, busy=0.
  - Then enable=0, idle_data=8'hA5 → gpio_data=8'hA5 one cycle later.
- Basic sequence:
  - Stimulus: enable=1, trigger pulse, commands {D=3,8'h01},{D=0,8'h02},{D=1,8'h04} always valid.
  - Required: gpio_data is 01 for 4 cycles, 02 for 1 cycle, then 04; handshakes at t, t+4, t+5; sts_count=3.
- Trigger gating:
  - Stimulus: enable=1, trigger=0 for 20 cycles with tvalid=1.
  - Required: tready=0, busy=1, gpio_data unchanged.
  - Then trigger=1 → first handshake 2 edges later.
- Underrun:
  - Stimulus: after one accepted {D=2,8'h10}, tvalid=0 for 5 cycles.
  - Required: underrun=1 sticky; gpio_data stays 8'h10; next command accepted normally.
  - Re-arm (enable 0→1) → underrun=0, sts_count=0.
- Disable mid-DELAY:
  - Stimulus: {D=100,8'hFF} accepted, then enable=0 at cycle 10.
  - Required: next edge gpio_data=idle_data, busy=0, tready=0, sts_count frozen at 1.
- Max delay / reset mid-run:
  - Stimulus: D=24'hFFFFFF.
  - Required: value held 2^24 cycles exactly (counter check, no wrap).
  - areset asserted mid-hold → all outputs at reset values next edge.
